// File: rtl/grid_row_packer_if.sv
// Byte-in / word-out handshake bundle for grid_row_packer.
// The slave modport is the packer side; the master modport is the feeder/consumer side.
interface grid_row_packer_if #(
    parameter int MODULAR_SIZE = 32
) ();
    logic [7:0]              in_byte;
    logic                    in_valid;
    logic                    in_ready;
    logic [MODULAR_SIZE-1:0] out_data;
    logic                    out_enable;

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_enable
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_enable
    );
endinterface

// File: rtl/grid_row_packer.sv
// Parses an ASCII grid stream into guard-padded rows and emits each row MS word first.
// Optional GRID_ROW_PACKER_ROLLCOUNT_EN adds roll_total, a saturating count of in-grid '@' cells.
module grid_row_packer #(
    parameter int ROW_SIZE     = 160,
    parameter int MODULAR_SIZE = 32,
    parameter int GRID_COLS    = 139,
    parameter int GRID_ROWS    = 139
) (
    input  logic                clk,
    input  logic                reset,
    grid_row_packer_if.slave    bus,
    output logic [15:0]         row_count,
    output logic                done,
    output logic                err_overflow,
    output logic                err_char
`ifdef GRID_ROW_PACKER_ROLLCOUNT_EN
    ,
    output logic [15:0]         roll_total
`endif
);

    localparam int WORDS_PER_ROW = ROW_SIZE / MODULAR_SIZE;
    localparam int COL_W         = $clog2(GRID_COLS + 1);
    localparam int IDX_W         = $clog2(ROW_SIZE);
    localparam int WORD_W        = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    localparam logic [COL_W-1:0]  COL_LIMIT = COL_W'(GRID_COLS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);
    localparam logic [15:0]       ROW_LIMIT = 16'(GRID_ROWS);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] CH_AT  = 8'h40;
    localparam logic [7:0] CH_DOT = 8'h2E;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;

    logic [1:0]              state_q,     state_d;
    logic [ROW_SIZE-1:0]     row_q,       row_d;
    logic [COL_W-1:0]        col_q,       col_d;
    logic [WORD_W-1:0]       word_q,      word_d;
    logic [15:0]             row_count_q, row_count_d;
    logic                    done_q,      done_d;
    logic                    err_ovf_q,   err_ovf_d;
    logic                    err_char_q,  err_char_d;
    logic                    in_ready_q,  in_ready_d;
    logic                    out_en_q,    out_en_d;
    logic [MODULAR_SIZE-1:0] out_data_q,  out_data_d;
`ifdef GRID_ROW_PACKER_ROLLCOUNT_EN
    logic [15:0]             roll_q,      roll_d;
`endif

    logic                    take_s;
    logic [IDX_W-1:0]        cell_idx_s;
    logic [ROW_SIZE-1:0]     shifted_s;

    // Column c sits just below the guard bit; words are taken from the top of a shifted copy.
    assign take_s     = bus.in_valid && in_ready_q && (state_q == ST_FILL);
    assign cell_idx_s = IDX_W'(ROW_SIZE - 2) - IDX_W'(col_q);
    assign shifted_s  = row_q << (int'(word_q) * MODULAR_SIZE);

    // Next-state and datapath for the FILL / EMIT / DONE controller.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        word_d      = word_q;
        row_count_d = row_count_q;
        done_d      = done_q;
        err_ovf_d   = err_ovf_q;
        err_char_d  = err_char_q;
        in_ready_d  = 1'b0;
        out_en_d    = 1'b0;
        out_data_d  = '0;
`ifdef GRID_ROW_PACKER_ROLLCOUNT_EN
        roll_d      = roll_q;
`endif
        case (state_q)
            ST_FILL: begin
                if (take_s) begin
                    case (bus.in_byte)
                        CH_AT, CH_DOT: begin
                            if (col_q < COL_LIMIT) begin
                                row_d[cell_idx_s] = (bus.in_byte == CH_AT);
                                col_d             = col_q + COL_W'(1);
`ifdef GRID_ROW_PACKER_ROLLCOUNT_EN
                                if ((bus.in_byte == CH_AT) && (roll_q != 16'hFFFF)) begin
                                    roll_d = roll_q + 16'd1;
                                end else begin
                                    roll_d = roll_q;
                                end
`endif
                            end else begin
                                err_ovf_d = 1'b1;
                            end
                        end
                        CH_CR: begin
                            state_d = ST_FILL;
                        end
                        CH_LF: begin
                            if (col_q != '0) begin
                                state_d = ST_EMIT;
                            end else begin
                                state_d = ST_FILL;
                            end
                        end
                        default: begin
                            err_char_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_FILL;
                end
                in_ready_d = (state_d == ST_FILL);
            end
            ST_EMIT: begin
                out_en_d   = 1'b1;
                out_data_d = shifted_s[ROW_SIZE-1 -: MODULAR_SIZE];
                if (word_q == LAST_WORD) begin
                    word_d      = '0;
                    row_d       = '0;
                    col_d       = '0;
                    row_count_d = row_count_q + 16'd1;
                    if (row_count_d == ROW_LIMIT) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // in_ready stays low this edge so it never overlaps the last word
                        state_d = ST_FILL;
                    end
                end else begin
                    word_d = word_q + WORD_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FILL;
            row_q       <= '0;
            col_q       <= '0;
            word_q      <= '0;
            row_count_q <= 16'd0;
            done_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_char_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_en_q    <= 1'b0;
            out_data_q  <= '0;
`ifdef GRID_ROW_PACKER_ROLLCOUNT_EN
            roll_q      <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            word_q      <= word_d;
            row_count_q <= row_count_d;
            done_q      <= done_d;
            err_ovf_q   <= err_ovf_d;
            err_char_q  <= err_char_d;
            in_ready_q  <= in_ready_d;
            out_en_q    <= out_en_d;
            out_data_q  <= out_data_d;
`ifdef GRID_ROW_PACKER_ROLLCOUNT_EN
            roll_q      <= roll_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_enable = out_en_q;
    assign bus.out_data   = out_data_q;
    assign row_count      = row_count_q;
    assign done           = done_q;
    assign err_overflow   = err_ovf_q;
    assign err_char       = err_char_q;
`ifdef GRID_ROW_PACKER_ROLLCOUNT_EN
    assign roll_total     = roll_q;
`endif

endmodule
